// File: rtl/ifetch_pkg.sv
// Shared constants and the default fetch-queue entry layout for the instruction fetch stage.
package ifetch_pkg;

  localparam int INSTR_NOP = 0;
  localparam int PC_STEP   = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ifetch_entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// Synchronous FIFO of fetch entries; flush has priority over push/pop, and a push is
// accepted while full when the head is popped in the same cycle.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = ifetch_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  output entry_t           head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: fetch PC, synchronous-read instruction memory, fetch queue and redirect.
// Optional IFETCH_FAULT_EN flags misaligned / out-of-range fetches instead of wrapping.
module instruction_fetch_unit
  import ifetch_pkg::*;
#(
  parameter int              ADDR_W      = 32,
  parameter int              INSTR_W     = 32,
  parameter int              IMEM_DEPTH  = 128,
  parameter int              QUEUE_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic               out_fault,
  input  logic               imem_we,
  input  logic [ADDR_W-1:0]  imem_waddr,
  input  logic [INSTR_W-1:0] imem_wdata
);

  localparam int IDX_W = $clog2(IMEM_DEPTH);
  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
    logic               fault;
  } entry_t;

  logic [INSTR_W-1:0] imem [IMEM_DEPTH];
  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  redirect_target;
  logic               fetch_fault;
  logic               issue;
  logic               pop;
  logic               push;
  logic [CNT_W-1:0]   count;
  logic [CNT_W:0]     occupancy;
  logic               vld_p1;
  logic [ADDR_W-1:0]  pc_p1;
  logic [INSTR_W-1:0] rdata_p1;
  logic               fault_p1;
  entry_t             push_entry;
  entry_t             head;
  logic               empty;
  logic               full;
  logic               unused_bits;

`ifdef IFETCH_FAULT_EN
  assign redirect_target = redirect_pc;
  assign fetch_fault     = (fetch_pc[1:0] != 2'b00) || (|fetch_pc[ADDR_W-1:IDX_W+2]);
  assign out_fault       = out_valid & head.fault;
`else
  assign redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign fetch_fault     = 1'b0;
  assign out_fault       = 1'b0;
`endif

  // Queue slots already committed: held entries plus the read in flight, minus this cycle's pop.
  assign pop       = out_valid & out_ready;
  assign occupancy = {1'b0, count} + (CNT_W+1)'(vld_p1) - (CNT_W+1)'(pop);
  assign issue     = !redirect_valid && (occupancy < (CNT_W+1)'(QUEUE_DEPTH));

  // Stage p0 -> p1: memory read and tag capture at issue
  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_waddr[IDX_W+1:2]] <= imem_wdata;
    if (issue && !fetch_fault) rdata_p1 <= imem[fetch_pc[IDX_W+1:2]];
    if (issue) begin
      pc_p1    <= fetch_pc;
      fault_p1 <= fetch_fault;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      vld_p1   <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_target;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= issue;
      if (issue) fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
    end
  end

  // Stage p1 -> queue: response written to the tail unless a redirect discards it
  assign push       = vld_p1 & ~redirect_valid;
  assign push_entry = '{pc:    pc_p1,
                        instr: fault_p1 ? INSTR_W'(INSTR_NOP) : rdata_p1,
                        fault: fault_p1};

  ifetch_queue #(
    .DEPTH   (QUEUE_DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign out_valid = ~empty;
  assign out_pc    = out_valid ? head.pc    : '0;
  assign out_instr = out_valid ? head.instr : '0;

  assign unused_bits = ^{imem_waddr[ADDR_W-1:IDX_W+2], imem_waddr[1:0],
                         redirect_pc[1:0], head.fault, full};

endmodule
